// File: rtl/regfile_dest_decode.sv
// MIPS register file, destination-decode side: 2**AW x DW flop array with $0 tied to zero,
// two rs/rt read ports, a debug read port and a committed-write counter. Optional macro: REGFILE_BYPASS_EN.
module regfile_dest_decode #(
  parameter int DW    = 32,
  parameter int AW    = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [DW-1:0]    wdata,
  input  logic [AW-1:0]    raddr1,
  output logic [DW-1:0]    rdata1,
  input  logic [AW-1:0]    raddr2,
  output logic [DW-1:0]    rdata2,
  input  logic [AW-1:0]    dbg_addr,
  output logic [DW-1:0]    dbg_data,
  output logic [CNT_W-1:0] wr_cnt,
  output logic [AW-1:0]    wr_last
);

  localparam int NREG = 1 << AW;

  logic [DW-1:0]    r_regs [NREG];
  logic [CNT_W-1:0] r_wr_cnt;
  logic [AW-1:0]    r_wr_last;

  // A write to $0 is dropped entirely; while reset is held nothing can commit,
  // so nothing is forwarded either.
  logic w_commit;
  assign w_commit = rst_n && we && (waddr != '0);

  // NOTE: every storage flop is cleared by the async reset, so this array must
  // stay in flops; it cannot be mapped onto a RAM macro that lacks a reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        r_regs[i] <= '0;
      end
      r_wr_cnt  <= '0;
      r_wr_last <= '0;
    end else if (w_commit) begin
      // NOTE: non-blocking updates keep same-edge reads seeing the pre-edge value.
      r_regs[waddr] <= wdata;
      r_wr_cnt      <= r_wr_cnt + CNT_W'(1);
      r_wr_last     <= waddr;
    end
  end

  logic [DW-1:0] w_stored1;
  logic [DW-1:0] w_stored2;
  logic [DW-1:0] w_stored_dbg;

  // NOTE: each always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_stored1    = '0;
    w_stored2    = '0;
    w_stored_dbg = '0;
    if (raddr1 != '0)   w_stored1    = r_regs[raddr1];
    if (raddr2 != '0)   w_stored2    = r_regs[raddr2];
    if (dbg_addr != '0) w_stored_dbg = r_regs[dbg_addr];
  end

`ifdef REGFILE_BYPASS_EN
  // Write-first forwarding for a future pipelined datapath; debug port never forwards.
  assign rdata1 = (w_commit && (raddr1 == waddr)) ? wdata : w_stored1;
  assign rdata2 = (w_commit && (raddr2 == waddr)) ? wdata : w_stored2;
`else
  assign rdata1 = w_stored1;
  assign rdata2 = w_stored2;
`endif

  assign dbg_data = w_stored_dbg;
  assign wr_cnt   = r_wr_cnt;
  assign wr_last  = r_wr_last;

endmodule

// File: tb/tb_regfile_dest_decode.sv
// Self-checking bench for regfile_dest_decode: reference model plus a scoreboard queue of
// expected register reads, and a CNT_W=4 instance for the counter wrap.
module tb_regfile_dest_decode;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int CNT_W = 16;

  logic             clk;
  logic             rst_n;
  logic             we;
  logic [AW-1:0]    waddr;
  logic [DW-1:0]    wdata;
  logic [AW-1:0]    raddr1;
  logic [DW-1:0]    rdata1;
  logic [AW-1:0]    raddr2;
  logic [DW-1:0]    rdata2;
  logic [AW-1:0]    dbg_addr;
  logic [DW-1:0]    dbg_data;
  logic [CNT_W-1:0] wr_cnt;
  logic [AW-1:0]    wr_last;

  logic             w_we;
  logic [AW-1:0]    w_waddr;
  logic [DW-1:0]    w_wdata;
  logic [AW-1:0]    w_raddr;
  logic [DW-1:0]    w_rdata1;
  logic [DW-1:0]    w_rdata2;
  logic [DW-1:0]    w_dbg_data;
  logic [3:0]       w_wr_cnt;
  logic [AW-1:0]    w_wr_last;

  regfile_dest_decode #(.DW(DW), .AW(AW), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr1(raddr1), .rdata1(rdata1), .raddr2(raddr2), .rdata2(rdata2),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data), .wr_cnt(wr_cnt), .wr_last(wr_last)
  );

  regfile_dest_decode #(.DW(DW), .AW(AW), .CNT_W(4)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .we(w_we), .waddr(w_waddr), .wdata(w_wdata),
    .raddr1(w_raddr), .rdata1(w_rdata1), .raddr2(w_raddr), .rdata2(w_rdata2),
    .dbg_addr(w_raddr), .dbg_data(w_dbg_data), .wr_cnt(w_wr_cnt), .wr_last(w_wr_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          addr;
    logic [31:0] data;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] model [32];
  int          model_cnt;
  int          model_last;
  int          n_tests;
  int          n_fail;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) model[i] = '0;
    model_cnt  = 0;
    model_last = 0;
  endtask

  task automatic expect_reg(input int a);
    exp_t e;
    e.addr = a;
    e.data = model[a];
    sb_q.push_back(e);
  endtask

  // Pops each expected read and compares all three read ports aimed at that address.
  task automatic drain();
    exp_t e;
    while (sb_q.size() > 0) begin
      e        = sb_q.pop_front();
      raddr1   = AW'(e.addr);
      raddr2   = AW'(e.addr);
      dbg_addr = AW'(e.addr);
      #1;
      check($sformatf("rdata1 r%0d", e.addr), 64'(rdata1), 64'(e.data));
      check($sformatf("rdata2 r%0d", e.addr), 64'(rdata2), 64'(e.data));
      check($sformatf("dbg r%0d", e.addr), 64'(dbg_data), 64'(e.data));
    end
  endtask

  task automatic check_ctrs(input string tag);
    check({tag, " wr_cnt"}, 64'(wr_cnt), 64'(model_cnt));
    check({tag, " wr_last"}, 64'(wr_last), 64'(model_last));
  endtask

  task automatic do_write(input int a, input logic [31:0] d);
    @(negedge clk);
    we    = 1'b1;
    waddr = AW'(a);
    wdata = d;
    @(posedge clk);
    #1;
    we = 1'b0;
    if (a != 0) begin
      model[a]   = d;
      model_cnt  = model_cnt + 1;
      model_last = a;
    end
  endtask

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    we       = 1'b0;
    waddr    = '0;
    wdata    = '0;
    raddr1   = '0;
    raddr2   = '0;
    dbg_addr = '0;
    w_we     = 1'b0;
    w_waddr  = '0;
    w_wdata  = '0;
    w_raddr  = '0;
    model_reset();

    #12;
    check_ctrs("in_reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 32; i++) expect_reg(i);
    drain();
    check_ctrs("after_reset");

    do_write(8, 32'hDEAD_BEEF);
    check_ctrs("basic");
    expect_reg(8); expect_reg(7); expect_reg(9);
    drain();

    do_write(0, 32'hFFFF_FFFF);
    check_ctrs("zero_write");
    expect_reg(0); expect_reg(8);
    drain();

    @(negedge clk);
    we    = 1'b0;
    waddr = 'x;
    wdata = 'x;
    @(posedge clk);
    #1;
    waddr = '0;
    wdata = '0;
    check_ctrs("we_low_x");
    expect_reg(8);
    drain();

    do_write(1, 32'h0000_0001);
    do_write(30, 32'h8000_0000);
    do_write(8, 32'hA5A5_5A5A);
    check_ctrs("multi");
    expect_reg(1); expect_reg(30); expect_reg(8); expect_reg(31);
    drain();

    // Same-cycle read/write of reg 5.
    do_write(5, 32'h1111_1111);
    @(negedge clk);
    we       = 1'b1;
    waddr    = 5'd5;
    wdata    = 32'h2222_2222;
    raddr1   = 5'd5;
    raddr2   = 5'd5;
    dbg_addr = 5'd5;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("same_cyc rdata2", 64'(rdata2), 64'h2222_2222);
    check("same_cyc rdata1", 64'(rdata1), 64'h2222_2222);
`else
    check("same_cyc rdata2", 64'(rdata2), 64'h1111_1111);
    check("same_cyc rdata1", 64'(rdata1), 64'h1111_1111);
`endif
    check("same_cyc dbg", 64'(dbg_data), 64'h1111_1111);
    @(posedge clk);
    #1;
    we         = 1'b0;
    model[5]   = 32'h2222_2222;
    model_cnt  = model_cnt + 1;
    model_last = 5;
    check_ctrs("same_cyc");
    expect_reg(5);
    drain();

    // Async reset between edges while a write is pending.
    do_write(31, 32'h1234_5678);
    expect_reg(31);
    drain();
    @(negedge clk);
    we     = 1'b1;
    waddr  = 5'd31;
    wdata  = 32'hAAAA_AAAA;
    raddr1 = 5'd31;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("async rdata1 r31", 64'(rdata1), 64'h0);
    check_ctrs("async");
    @(posedge clk);
    #1;
    @(negedge clk);
    we    = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_ctrs("post_release");
    expect_reg(31); expect_reg(5); expect_reg(8);
    drain();

    do_write(2, 32'h600D_F00D);
    check_ctrs("post_reset_write");
    expect_reg(2); expect_reg(31);
    drain();

    // 17 commits on the CNT_W=4 instance: counter wraps through 0 to 1.
    for (int k = 0; k < 17; k++) begin
      @(negedge clk);
      w_we    = 1'b1;
      w_waddr = 5'd3;
      w_wdata = 32'h0000_0100 + 32'(k);
      @(posedge clk);
      #1;
      w_we = 1'b0;
    end
    w_raddr = 5'd3;
    #1;
    check("wrap wr_cnt", 64'(w_wr_cnt), 64'd1);
    check("wrap wr_last", 64'(w_wr_last), 64'd3);
    check("wrap rdata1 r3", 64'(w_rdata1), 64'h0000_0110);
    check("wrap dbg r3", 64'(w_dbg_data), 64'h0000_0110);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
